fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Consumer of the program counter's address stream and driver of its redirect inputs (pc_next/pc_branch).
- Issues instruction-memory read requests for pc_out, tracks in-flight requests, and buffers returned instructions with their PCs in an in-order queue for decode.
- Holds the PC on stall by re-presenting the current address through the branch path.
- Applies execute-stage redirects and discards stale responses after a flush.

Parameters:
XLEN, 64, address/PC width
DEPTH, 4, instruction queue entries; also the bound on outstanding + queued fetches (power of 2, >=2)
ILEN, 32, instruction word width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
pc_in  in  XLEN  current PC from program counter (pc_out)
pc_next  out  XLEN  next-PC value to program counter
pc_branch  out  1  load pc_next into PC instead of +4
redirect_valid  in  1  execute-stage redirect (taken branch/jump)
redirect_target  in  XLEN  redirect address
imem_req_valid  out  1  read request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  request address
imem_rsp_valid  in  1  response valid; responses in request order, always accepted
imem_rsp_data  in  ILEN  instruction word
inst_valid  out  1  queue head valid
inst_ready  in  1  decode accepts head
inst_data  out  ILEN  head instruction
inst_pc  out  XLEN  head PC
fetch_misaligned  out  1  sticky: pc_in[1:0]!=0 seen; issue halted

Behaviour:
- Reset (synchronous, active-high): queue empty, outstanding=0, discard=0, fetch_misaligned=0. During reset, inst_valid=0 and imem_req_valid=0. pc_branch=0 and pc_next=pc_in, because the PC resets itself.
- Credit rule: can_issue = (outstanding + count) < DEPTH, no redirect_valid, fetch_misaligned=0, pc_in[1:0]==0. The count term is the number of queued entries before this cycle's pop.
- imem_req_valid = can_issue (combinational). imem_req_addr = pc_in. Issue fires on imem_req_valid & imem_req_ready.
- Issue fire pushes pc_in into the in-flight PC FIFO (DEPTH entries) and increments outstanding.
- PC control (combinational):
  - redirect_valid: pc_branch=1, pc_next=redirect_target.
  - else no issue fire: pc_branch=1, pc_next=pc_in (hold).
  - else: pc_branch=0, so the PC increments by 4.
- Response, discard>0: drop data, pop the in-flight PC, decrement discard and outstanding.
- Response, discard==0: push {imem_rsp_data, popped PC} into the queue, decrement outstanding. Queue cannot overflow (credit rule).
- Response handshake is simultaneous with issue fire: outstanding net unchanged.
- Pop: inst_valid & inst_ready. inst_valid = count!=0. inst_data/inst_pc are registered queue-head values. Pop and push in the same cycle are allowed at any occupancy, including full.
- Fetch latency: a response in cycle N makes inst_valid=1 from cycle N+1.
- Redirect (cycle R):
  - Queue cleared at end of R; any pop in R is ignored (inst_valid forced 0 in R).
  - discard <= discard + outstanding - (rsp in R ? 1 : 0). A response in R is itself dropped.
  - fetch_misaligned cleared. No issue in R. The first fetch of the target is issued in R+1 or later.
- Misaligned: pc_in[1:0]!=0 with no redirect sets fetch_misaligned next cycle. Issue halts and the PC holds until a redirect.
- Counters: outstanding and discard are log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- No combinational path from imem_rsp_* to inst_*.

Test Plan:
1. Reset then imem_req_ready=1 and 1-cycle response latency from pc 0x0 -> requests at 0x0, 0x4, 0x8, 0xC. inst_pc follows the same sequence with matching data. pc_branch=0 in steady state.
2. inst_ready=0 with DEPTH=4 -> at most 4 issues. Then imem_req_valid=0, pc_branch=1, pc_next=pc_in, and the PC holds at 0x10. Assert inst_ready: entries drain and issue resumes at 0x10.
3. imem_req_ready=0 for 3 cycles -> PC holds, imem_req_addr stable. No queue change.
4. Two requests outstanding (0x20, 0x24), redirect to 0x100 -> queue empty next cycle, both stale responses dropped. First inst_pc=0x100.
5. Redirect in the same cycle as a response and a decode pop -> the response is dropped, the pop is ignored, and discard = outstanding-1.
6. Redirect to 0x102 -> fetch_misaligned=1, no requests. Redirect to 0x200 -> flag clears and fetch resumes at 0x200.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory and decode.
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [ILEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: issues reads for the current PC, tracks in-flight PCs,
// queues returned words for decode, and steers the PC on stall/redirect.
module fetch_unit #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int ILEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_branch,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    fetch_unit_if.master    bus,
    output logic            fetch_misaligned
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ILEN-1:0] data;
        logic [XLEN-1:0] pc;
    } inst_entry_t;

    logic [XLEN-1:0] ifl_pc_q [DEPTH];
    logic [XLEN-1:0] ifl_pc_d [DEPTH];
    logic [PW-1:0]   ifl_wr_q, ifl_wr_d;
    logic [PW-1:0]   ifl_rd_q, ifl_rd_d;

    inst_entry_t     iq_q [DEPTH];
    inst_entry_t     iq_d [DEPTH];
    logic [PW-1:0]   iq_wr_q, iq_wr_d;
    logic [PW-1:0]   iq_rd_q, iq_rd_d;
    logic [CW-1:0]   count_q, count_d;

    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            misaligned_q, misaligned_d;

    logic            credit_ok, pc_aligned, can_issue, issue_fire;
    logic            rsp, push, pop, inst_vld;

    // Credits cover both in-flight and queued words, so the queue never overflows.
    assign credit_ok  = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW+1)'(DEPTH);
    assign pc_aligned = (pc_in[1:0] == 2'b00);
    assign can_issue  = !reset && credit_ok && !redirect_valid && !misaligned_q && pc_aligned;
    assign issue_fire = can_issue && bus.imem_req_ready;
    assign inst_vld   = !reset && (count_q != '0) && !redirect_valid;
    assign pop        = inst_vld && bus.inst_ready;
    assign rsp        = bus.imem_rsp_valid;
    assign push       = rsp && (discard_q == '0) && !redirect_valid;

    assign bus.imem_req_valid = can_issue;
    assign bus.imem_req_addr  = pc_in;
    assign bus.inst_valid     = inst_vld;
    assign bus.inst_data      = iq_q[iq_rd_q].data;
    assign bus.inst_pc        = iq_q[iq_rd_q].pc;
    assign fetch_misaligned   = misaligned_q;

    // Holding the PC is done by reloading pc_in through the branch path.
    always_comb begin
        pc_branch = 1'b0;
        pc_next   = pc_in;
        if (!reset) begin
            if (redirect_valid) begin
                pc_branch = 1'b1;
                pc_next   = redirect_target;
            end else if (!issue_fire) begin
                pc_branch = 1'b1;
            end
        end
    end

    always_comb begin
        ifl_pc_d      = ifl_pc_q;
        ifl_wr_d      = ifl_wr_q;
        ifl_rd_d      = ifl_rd_q;
        iq_d          = iq_q;
        iq_wr_d       = iq_wr_q;
        iq_rd_d       = iq_rd_q;
        count_d       = count_q;
        discard_d     = discard_q;
        misaligned_d  = misaligned_q;
        outstanding_d = outstanding_q + CW'(issue_fire) - CW'(rsp);

        if (issue_fire) begin
            ifl_pc_d[ifl_wr_q] = pc_in;
            ifl_wr_d           = ifl_wr_q + 1'b1;
        end
        if (rsp) ifl_rd_d = ifl_rd_q + 1'b1;

        if (redirect_valid) begin
            // Everything still in flight becomes stale; a response this cycle is dropped too.
            discard_d    = discard_q + outstanding_q - CW'(rsp);
            iq_wr_d      = '0;
            iq_rd_d      = '0;
            count_d      = '0;
            misaligned_d = 1'b0;
        end else begin
            if (rsp && (discard_q != '0)) discard_d = discard_q - 1'b1;
            if (push) begin
                iq_d[iq_wr_q] = '{data: bus.imem_rsp_data, pc: ifl_pc_q[ifl_rd_q]};
                iq_wr_d       = iq_wr_q + 1'b1;
            end
            if (pop) iq_rd_d = iq_rd_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
            if (!pc_aligned) misaligned_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ifl_wr_q      <= '0;
            ifl_rd_q      <= '0;
            iq_wr_q       <= '0;
            iq_rd_q       <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            ifl_wr_q      <= ifl_wr_d;
            ifl_rd_q      <= ifl_rd_d;
            iq_wr_q       <= iq_wr_d;
            iq_rd_q       <= iq_rd_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            misaligned_q  <= misaligned_d;
        end
    end

    // Storage arrays carry no reset; valid state lives in the pointers/counters.
    always_ff @(posedge clk) begin
        ifl_pc_q <= ifl_pc_d;
        iq_q     <= iq_d;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a PC register and an in-order imem model
// with 1-cycle latency surround the DUT; expected values are hand-computed.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_in, pc_next, redirect_target;
    logic        pc_branch, redirect_valid, fetch_misaligned;
    logic        rsp_en;
    logic [63:0] pend[$];
    int          n_vec = 0;
    int          n_err = 0;

    fetch_unit_if #(.XLEN(64), .ILEN(32)) bus ();

    fetch_unit #(.XLEN(64), .DEPTH(4), .ILEN(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_in            (pc_in),
        .pc_next          (pc_next),
        .pc_branch        (pc_branch),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .bus              (bus),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return 32'hA500_0000 | a[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, update PC and memory model after it.
    task automatic step();
        logic        fire, rv, br, rst;
        logic [63:0] a, nx;
        #1;
        fire = bus.imem_req_valid & bus.imem_req_ready;
        a    = bus.imem_req_addr;
        rv   = bus.imem_rsp_valid;
        br   = pc_branch;
        nx   = pc_next;
        rst  = reset;
        @(posedge clk);
        #1;
        if (rst) begin
            pc_in = 64'h0;
            pend.delete();
        end else begin
            pc_in = br ? nx : pc_in + 64'd4;
            if (rv) void'(pend.pop_front());
            if (fire) pend.push_back(a);
        end
        bus.imem_rsp_valid = rsp_en && (pend.size() != 0);
        bus.imem_rsp_data  = (pend.size() != 0) ? word_of(pend[0]) : 32'h0;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; pc_in = 64'h0; redirect_valid = 1'b0; redirect_target = 64'h0;
        rsp_en = 1'b1;
        bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;

        step();
        chk("rst_inst_valid", bus.inst_valid, 0);
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_pc_branch", pc_branch, 0);
        chk("rst_pc_next", pc_next, 64'h0);
        chk("rst_misaligned", fetch_misaligned, 0);
        step();
        reset = 1'b0;
        #1;

        // Streaming fetch from 0x0 with decode always ready
        for (int k = 0; k < 4; k++) begin
            chk("t1_req_valid", bus.imem_req_valid, 1);
            chk("t1_req_addr", bus.imem_req_addr, 64'(4 * k));
            chk("t1_pc_branch", pc_branch, 0);
            if (k >= 2) begin
                chk("t1_inst_valid", bus.inst_valid, 1);
                chk("t1_inst_pc", bus.inst_pc, 64'(4 * (k - 2)));
                chk("t1_inst_data", bus.inst_data, word_of(64'(4 * (k - 2))));
            end
            step();
        end

        // Decode stalled: credits stop issue after four fetches
        do_reset();
        bus.inst_ready = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_req_addr", bus.imem_req_addr, 64'(4 * k));
            step();
        end
        chk("t2_full_req_valid", bus.imem_req_valid, 0);
        chk("t2_full_pc_branch", pc_branch, 1);
        chk("t2_full_pc_next", pc_next, 64'h10);
        step();
        chk("t2_hold_req_valid", bus.imem_req_valid, 0);
        chk("t2_hold_pc_next", pc_next, 64'h10);
        chk("t2_head_pc", bus.inst_pc, 64'h0);
        chk("t2_head_data", bus.inst_data, 32'hA500_0000);
        bus.inst_ready = 1'b1;
        #1;
        step();
        chk("t2_resume_valid", bus.imem_req_valid, 1);
        chk("t2_resume_addr", bus.imem_req_addr, 64'h10);
        chk("t2_drain_pc4", bus.inst_pc, 64'h4);
        step();
        chk("t2_drain_pc8", bus.inst_pc, 64'h8);
        step();
        chk("t2_drain_pcC", bus.inst_pc, 64'hC);
        step();
        chk("t2_drain_pc10", bus.inst_pc, 64'h10);
        chk("t2_drain_d10", bus.inst_data, 32'hA500_0010);
        step();

        // Memory not ready: PC and request address hold, queue frozen
        bus.imem_req_ready = 1'b0;
        bus.inst_ready = 1'b0;
        #1;
        step();
        for (int k = 0; k < 3; k++) begin
            chk("t3_req_valid", bus.imem_req_valid, 1);
            chk("t3_req_addr", bus.imem_req_addr, 64'h20);
            chk("t3_pc_branch", pc_branch, 1);
            chk("t3_pc_next", pc_next, 64'h20);
            chk("t3_inst_pc", bus.inst_pc, 64'h14);
            if (k < 2) step();
        end

        // Two fetches held in memory, then redirect to 0x100
        bus.inst_ready = 1'b1; rsp_en = 1'b0; bus.imem_req_ready = 1'b1;
        #1;
        step();
        chk("t4_addr24", bus.imem_req_addr, 64'h24);
        step();
        bus.imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 64'h100;
        #1;
        chk("t4_redir_req_valid", bus.imem_req_valid, 0);
        chk("t4_redir_pc_branch", pc_branch, 1);
        chk("t4_redir_pc_next", pc_next, 64'h100);
        chk("t4_redir_inst_valid", bus.inst_valid, 0);
        step();
        redirect_valid = 1'b0; rsp_en = 1'b1; bus.imem_req_ready = 1'b1;
        #1;
        chk("t4_target_req_valid", bus.imem_req_valid, 1);
        chk("t4_target_addr", bus.imem_req_addr, 64'h100);
        for (int k = 0; k < 4; k++) begin
            chk("t4_flushed_empty", bus.inst_valid, 0);
            step();
        end
        chk("t4_first_valid", bus.inst_valid, 1);
        chk("t4_first_pc", bus.inst_pc, 64'h100);
        chk("t4_first_data", bus.inst_data, 32'hA500_0100);
        chk("t4_credit_full", bus.imem_req_valid, 0);
        step();
        chk("t4_second_pc", bus.inst_pc, 64'h104);
        step();

        // Redirect coinciding with a response and a decode pop
        redirect_valid = 1'b1; redirect_target = 64'h180;
        #1;
        chk("t5_redir_inst_valid", bus.inst_valid, 0);
        chk("t5_rsp_present", bus.imem_rsp_valid, 1);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t5_empty1", bus.inst_valid, 0);
        step();
        chk("t5_empty2", bus.inst_valid, 0);
        step();
        chk("t5_first_valid", bus.inst_valid, 1);
        chk("t5_first_pc", bus.inst_pc, 64'h180);
        chk("t5_first_data", bus.inst_data, 32'hA500_0180);

        // Misaligned redirect halts fetch until the next redirect
        redirect_valid = 1'b1; redirect_target = 64'h102;
        #1;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t6_mis_req_valid", bus.imem_req_valid, 0);
        chk("t6_mis_pc_branch", pc_branch, 1);
        chk("t6_mis_pc_next", pc_next, 64'h102);
        chk("t6_flag_pre", fetch_misaligned, 0);
        step();
        chk("t6_flag_set", fetch_misaligned, 1);
        chk("t6_halt_req_valid", bus.imem_req_valid, 0);
        step();
        redirect_valid = 1'b1; redirect_target = 64'h200;
        #1;
        chk("t6_flag_held", fetch_misaligned, 1);
        chk("t6_fix_pc_next", pc_next, 64'h200);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t6_flag_clear", fetch_misaligned, 0);
        chk("t6_resume_valid", bus.imem_req_valid, 1);
        chk("t6_resume_addr", bus.imem_req_addr, 64'h200);
        step();
        step();
        chk("t6_inst_valid", bus.inst_valid, 1);
        chk("t6_inst_pc", bus.inst_pc, 64'h200);
        chk("t6_inst_data", bus.inst_data, 32'hA500_0200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
